sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; successor to the fixed 4x8 FIFO. Generalised width/depth.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/sync_fifo_param_if.sv | 60 ++++++
 rtl/fifo_ram.sv | 41 ++++
 rtl/sync_fifo_param.sv | 118 +++++++++++
 tb/tb_sync_fifo_param.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared constants and helpers for sync_fifo_param and its sub-modules.
//   Contents:
//     DEF_DATA_W  default data word width
//     DEF_ADDR_W  default pointer width (DEPTH = 2**ADDR_W)
//     cnt_w()     width of the occupancy count (must hold 0..DEPTH)
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

  // The count has to represent DEPTH itself, so it needs one bit more than
  // the pointers.
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_if
//   Bundle of FIFO handshake, data and status signals.
//   Modports:
//     master  producer/consumer side: drives push, push_data, pop;
//             observes pop_data, flags, count (and error flags when built in)
//     slave   FIFO side: the mirror image of master
//   Handshake: a push is taken at the rising clock edge when push is high and
//   the FIFO is not full, or is full but pops in the same cycle. A pop is
//   taken at the rising clock edge when pop is high and the FIFO is not
//   empty. There is no back-pressure signal; the producer watches full and
//   the consumer watches empty. pop_data always shows the current head.
//   Build option: SYNC_FIFO_ERR_EN adds the sticky overflow/underflow flags.
// ---------------------------------------------------------------------------
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  localparam int CNT_W = cnt_w(ADDR_W);

  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic [DATA_W-1:0] pop_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
`ifdef SYNC_FIFO_ERR_EN
  logic              overflow;
  logic              underflow;
`endif

`ifdef SYNC_FIFO_ERR_EN
  modport master (
    output push, push_data, pop,
    input  pop_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
  modport slave (
    input  push, push_data, pop,
    output pop_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
`else
  modport master (
    output push, push_data, pop,
    input  pop_data, full, empty, almost_full, almost_empty, count
  );
  modport slave (
    input  push, push_data, pop,
    output pop_data, full, empty, almost_full, almost_empty, count
  );
`endif

endinterface

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
//   DEPTH x DATA_W storage array: synchronous write, asynchronous read.
//   Ports:
//     clk      rising-edge clock
//     wr_i     write enable
//     waddr_i  write address
//     wdata_i  write data
//     raddr_i  read address
//     rdata_o  read data, combinational from mem[raddr_i]
//   Contents are not reset.
// ---------------------------------------------------------------------------
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Show-ahead read: in the full push+pop case the old head is read here
  // during the cycle, and the same slot is overwritten at the edge.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO with occupancy count, programmable
//   almost-full / almost-empty flags and full-state push+pop pass-through.
//   Parameters:
//     DATA_W     data word width
//     ADDR_W     pointer width, DEPTH = 2**ADDR_W (ADDR_W >= 1)
//     AF_THRESH  almost_full when count >= AF_THRESH (1..DEPTH)
//     AE_THRESH  almost_empty when count <= AE_THRESH (0..DEPTH-1)
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset
//     fifo_if  slave modport of sync_fifo_param_if (push/pop, data, flags,
//              count; overflow/underflow when SYNC_FIFO_ERR_EN is defined)
//   Build option: define SYNC_FIFO_ERR_EN for sticky overflow/underflow flags.
// ---------------------------------------------------------------------------
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_param_if.slave  fifo_if
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = cnt_w(ADDR_W);

  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W-1:0] rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              full_q;
  logic              empty_q;
  logic              af_q;
  logic              ae_q;
  logic              push_ok;
  logic              pop_ok;

  // Acceptance uses the registered flags only. A push into a full FIFO is
  // allowed when a pop frees the head slot in the same cycle.
  assign push_ok = fifo_if.push & (~full_q | fifo_if.pop);
  assign pop_ok  = fifo_if.pop & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally at DEPTH; full/empty come from the count, so no
  // extra wrap bit is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + ADDR_W'(1);
      if (pop_ok)  rptr_q <= rptr_q + ADDR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
      af_q    <= (count_d >= CNT_W'(AF_THRESH));
      ae_q    <= (count_d <= CNT_W'(AE_THRESH));
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_i    (push_ok),
    .waddr_i (wptr_q),
    .wdata_i (fifo_if.push_data),
    .raddr_i (rptr_q),
    .rdata_o (fifo_if.pop_data)
  );

  assign fifo_if.count        = count_q;
  assign fifo_if.full         = full_q;
  assign fifo_if.empty        = empty_q;
  assign fifo_if.almost_full  = af_q;
  assign fifo_if.almost_empty = ae_q;

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q;
  logic unf_q;

  // Sticky until reset: record any push refused for lack of space and any
  // pop attempted with nothing stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (fifo_if.push & full_q & ~fifo_if.pop) ovf_q <= 1'b1;
      if (fifo_if.pop & empty_q)                unf_q <= 1'b1;
    end
  end

  assign fifo_if.overflow  = ovf_q;
  assign fifo_if.underflow = unf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//   Bench for sync_fifo_param at DATA_W=8, ADDR_W=2, AF_THRESH=3, AE_THRESH=1.
//   A queue-based model tracks the FIFO contents; a negedge process compares
//   count, flags and head data against it every cycle. Directed sequences
//   add literal expectations, followed by random push/pop traffic.
//   Honours SYNC_FIFO_ERR_EN for the overflow/underflow flags.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int AF_TH  = 3;
  localparam int AE_TH  = 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic chk_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fif ();

  sync_fifo_param #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .AF_THRESH (AF_TH),
    .AE_THRESH (AE_TH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fifo_if (fif.slave)
  );

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] exp_q[$];
  bit m_ovf;
  bit m_unf;

  always @(posedge clk or negedge rst_n) begin
    int  sz;
    bit  take_push;
    bit  take_pop;
    if (!rst_n) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      sz        = exp_q.size();
      take_pop  = fif.pop && (sz > 0);
      take_push = fif.push && ((sz < DEPTH) || fif.pop);
      if (fif.push && sz == DEPTH && !fif.pop) m_ovf = 1'b1;
      if (fif.pop && sz == 0) m_unf = 1'b1;
      if (take_pop) void'(exp_q.pop_front());
      if (take_push) exp_q.push_back(fif.push_data);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    int sz;
    if (chk_en) begin
      sz = exp_q.size();
      chk("count", 32'(fif.count), 32'(sz));
      chk("empty", 32'(fif.empty), 32'(sz == 0));
      chk("full", 32'(fif.full), 32'(sz == DEPTH));
      chk("almost_full", 32'(fif.almost_full), 32'(sz >= AF_TH));
      chk("almost_empty", 32'(fif.almost_empty), 32'(sz <= AE_TH));
      if (sz > 0) chk("pop_data", 32'(fif.pop_data), 32'(exp_q[0]));
`ifdef SYNC_FIFO_ERR_EN
      chk("overflow", 32'(fif.overflow), 32'(m_ovf));
      chk("underflow", 32'(fif.underflow), 32'(m_unf));
`endif
    end
  end

  // ---------------- driver ----------------
  // Inputs change at the falling edge, are taken at the rising edge and are
  // released 1 time unit later; literal checks right after a step see the
  // post-edge state.
  task automatic step(input bit p, input logic [DATA_W-1:0] d, input bit o);
    @(negedge clk);
    fif.push      = p;
    fif.push_data = d;
    fif.pop       = o;
    @(posedge clk);
    #1;
    fif.push = 1'b0;
    fif.pop  = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] fill_v [4];
    logic [DATA_W-1:0] pass_v [4];
    fill_v = '{8'h11, 8'h22, 8'h33, 8'h44};
    pass_v = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    fif.push      = 1'b0;
    fif.pop       = 1'b0;
    fif.push_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 1: reset in the middle of a burst
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h5B, 1'b0);
    chk("pre_reset_count", 32'(fif.count), 32'd2);
    @(negedge clk);
    fif.push = 1'b1;
    fif.push_data = 8'h5C;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(fif.count), 32'd0);
    chk("rst_empty", 32'(fif.empty), 32'd1);
    chk("rst_full", 32'(fif.full), 32'd0);
    chk("rst_almost_empty", 32'(fif.almost_empty), 32'd1);
    chk("rst_almost_full", 32'(fif.almost_full), 32'd0);
    fif.push = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 2: fill, then a dropped push
    step(1'b1, 8'h11, 1'b0);
    chk("fill1_count", 32'(fif.count), 32'd1);
    chk("fill1_ae", 32'(fif.almost_empty), 32'd1);
    step(1'b1, 8'h22, 1'b0);
    chk("fill2_ae", 32'(fif.almost_empty), 32'd0);
    chk("fill2_af", 32'(fif.almost_full), 32'd0);
    step(1'b1, 8'h33, 1'b0);
    chk("fill3_af", 32'(fif.almost_full), 32'd1);
    chk("fill3_full", 32'(fif.full), 32'd0);
    step(1'b1, 8'h44, 1'b0);
    chk("fill4_full", 32'(fif.full), 32'd1);
    chk("fill4_count", 32'(fif.count), 32'd4);
    step(1'b1, 8'h55, 1'b0);
    chk("drop_count", 32'(fif.count), 32'd4);
    chk("drop_head", 32'(fif.pop_data), 32'h11);
`ifdef SYNC_FIFO_ERR_EN
    chk("overflow_set", 32'(fif.overflow), 32'd1);
`endif

    // 3: drain in order, then an ignored pop
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(fif.pop_data), 32'(fill_v[i]));
      step(1'b0, 8'h00, 1'b1);
    end
    chk("drain_empty", 32'(fif.empty), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("underpop_count", 32'(fif.count), 32'd0);
`ifdef SYNC_FIFO_ERR_EN
    chk("underflow_set", 32'(fif.underflow), 32'd1);
`endif

    // 4: push+pop while full
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
    chk("pass_head", 32'(fif.pop_data), 32'hA0);
    step(1'b1, 8'hB0, 1'b1);
    chk("pass_full", 32'(fif.full), 32'd1);
    chk("pass_count", 32'(fif.count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("pass_drain", 32'(fif.pop_data), 32'(pass_v[i]));
      step(1'b0, 8'h00, 1'b1);
    end

    // 5: push+pop while empty
    step(1'b1, 8'hC3, 1'b1);
    chk("ep_count", 32'(fif.count), 32'd1);
    chk("ep_empty", 32'(fif.empty), 32'd0);
    chk("ep_data", 32'(fif.pop_data), 32'hC3);
    step(1'b0, 8'h00, 1'b1);

    // 6: pointer wrap with alternating push/pop
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("wrap_data", 32'(fif.pop_data), 32'(i));
      chk("wrap_count", 32'(fif.count), 32'd1);
      step(1'b0, 8'h00, 1'b1);
    end

    // random traffic in phases biased toward filling and draining
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 100; c++) begin
        int pp;
        int op;
        pp = (ph % 2 == 0) ? 75 : 30;
        op = (ph % 2 == 0) ? 30 : 75;
        step($urandom_range(99, 0) < pp, 8'($urandom), $urandom_range(99, 0) < op);
      end
    end
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
